// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch path: prefetch entry layout and fetch FSM states.
// No logic; no latency or backpressure of its own.
package fetch_pkg;
  localparam int INSTR_BYTES = 4;
  localparam int FETCH_AW    = 32;
  localparam int FETCH_DW    = 32;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {FETCH, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch circular buffer of fetch entries, synchronous write, combinational head read.
// Latency: write visible at head next cycle. Backpressure: caller must not push when full unless popping.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t rd_entry,
  output logic         full,
  output logic         empty,
  output logic [PW:0]  count
);
  fetch_entry_t    store [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data-only; validity is tracked by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push && !flush) store[wr_ptr] <= wr_entry;
  end

  assign rd_entry = store[rd_ptr];
  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns fetch PC, fills prefetch FIFO from comb imem, redirect flushes. Optional FETCH_HALT_ZERO_EN.
// Latency: pushed word at head next cycle; redirected word presented two cycles after redirect.
// Backpressure: instr_valid/instr_ready; fetch stalls while FIFO is full and not popping.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       DEPTH         = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  localparam int                      PW            = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rd,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     instr_valid,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  input  logic                     instr_ready,
  output logic                     halted
);
  logic [ADDRESS_WIDTH-1:0] fpc;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic [PW:0]              count;
  fetch_entry_t             wr_entry;
  fetch_entry_t             head;

  // A redirect cancels both sides of the FIFO in its cycle; flush wins.
  assign pop  = instr_valid & instr_ready & ~redirect_valid;
  assign push = ~redirect_valid & ~halted & (~full | pop);

  assign wr_entry.pc    = fpc;
  assign wr_entry.instr = imem_rd;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .rd_entry (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc <= RESET_PC;
    end else if (redirect_valid) begin
      fpc <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
    end else if (push) begin
      fpc <= fpc + ADDRESS_WIDTH'(INSTR_BYTES);
    end
  end

  assign imem_addr   = fpc;
  assign instr_valid = (count != '0);
  assign instr       = empty ? '0 : head.instr;
  assign instr_pc    = empty ? '0 : head.pc;

`ifdef FETCH_HALT_ZERO_EN
  fetch_state_t state;
  fetch_state_t state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // The zero word itself is enqueued; only later fetches are suppressed.
  always_comb begin
    state_nxt = state;
    if (redirect_valid)              state_nxt = FETCH;
    else if (push && imem_rd == '0)  state_nxt = HALT;
  end

  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif
endmodule
